// File: rtl/core_halt_mgr_pkg.sv
// Shared definitions for the core halt manager.
//   NUM_CPUS          default number of requesters / halt outputs (legal 2..4)
//   ADDR              default address of the halt-control register
//   halt_t            halt command codes carried in the write data
//   core_mgr_state_t  manager FSM states
//   decode_halt()     maps a halt_t code to {target core, halt/release}
package core_halt_mgr_pkg;

    localparam int          NUM_CPUS = 2;
    localparam logic [31:0] ADDR     = 32'h8000_0000;

    // Core 0 owns codes 6/7; core i >= 1 owns 2(i-1) (halt) and 2(i-1)+1 (release).
    typedef enum logic [2:0] {
        HALTC1  = 3'd0,
        NHALTC1 = 3'd1,
        HALTC2  = 3'd2,
        NHALTC2 = 3'd3,
        HALTC3  = 3'd4,
        NHALTC3 = 3'd5,
        HALTC0  = 3'd6,
        NHALTC0 = 3'd7
    } halt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } core_mgr_state_t;

    typedef struct packed {
        logic [1:0] core;  // target core index
        logic       halt;  // 1 = halt, 0 = release
    } halt_dec_t;

    function automatic halt_dec_t decode_halt(input halt_t code);
        halt_dec_t  d;
        logic [2:0] c;
        c      = code;
        d.halt = ~c[0];
        if (c[2:1] == 2'b11) begin
            d.core = 2'd0;
        end else begin
            d.core = c[2:1] + 2'd1;
        end
        return d;
    endfunction

endpackage

// File: rtl/core_halt_mgr_if.sv
// Requester bus of the core halt manager.
//   req_valid/req_we/req_addr/req_wdata : per-requester access, driven by requesters
//   req_ack/req_err/rdata/halt_o        : completion, read data and halt lines from the manager
// Handshake: a requester raises req_valid[i] with stable we/addr/wdata and holds it
// until it sees the one-cycle req_ack[i] pulse; req_err[i] and rdata are only
// meaningful in that cycle. The requester then drops req_valid[i] (or keeps it
// high to issue a further access).
interface core_halt_mgr_if #(
    parameter int NUM_CPUS = core_halt_mgr_pkg::NUM_CPUS
);
    logic [NUM_CPUS-1:0]       req_valid;
    logic [NUM_CPUS-1:0]       req_we;
    logic [NUM_CPUS-1:0][31:0] req_addr;
    logic [NUM_CPUS-1:0][31:0] req_wdata;
    logic [NUM_CPUS-1:0]       req_ack;
    logic [NUM_CPUS-1:0]       req_err;
    logic [31:0]               rdata;
    logic [NUM_CPUS-1:0]       halt_o;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ack, req_err, rdata, halt_o
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ack, req_err, rdata, halt_o
    );
endinterface

// File: rtl/core_halt_mgr_rr_arbiter.sv
// Round-robin arbiter used by the core halt manager.
//   req   : request vector
//   ptr   : index with highest priority this round
//   grant : one-hot winner
//   valid : any request present
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    // Scan from ptr upward with wrap; the first requester found wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int off = 0; off < N; off++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid && (i == (int'(ptr) + off) % N) && req[i]) begin
                    grant[i] = 1'b1;
                    valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/core_halt_mgr.sv
// Core halt manager: arbitrates register accesses from NUM_CPUS requesters and
// drives one halt line per core.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : core_halt_mgr_if slave (requests in; ack/err/rdata/halt_o out)
//   dbg_state  : current FSM state
// Optional feature: define CORE_MGR_READBACK_EN to let reads at CTRL_ADDR return
// the halt vector; otherwise every read completes with err=1 and rdata=0.
// Each access takes IDLE (sample) -> EXEC (ack) -> RESP (ack drops, pointer moves).
module core_halt_mgr #(
    parameter int          NUM_CPUS  = core_halt_mgr_pkg::NUM_CPUS,
    parameter logic [31:0] CTRL_ADDR = core_halt_mgr_pkg::ADDR
) (
    input  logic                              clk,
    input  logic                              rst_n,
    core_halt_mgr_if.slave                    bus,
    output core_halt_mgr_pkg::core_mgr_state_t dbg_state
);
    import core_halt_mgr_pkg::*;

    localparam int PW = $clog2(NUM_CPUS);
    // Core 0 boots, all others start parked.
    localparam logic [NUM_CPUS-1:0] HALT_RST = {{(NUM_CPUS-1){1'b1}}, 1'b0};

    core_mgr_state_t     state_q, state_d;
    logic [PW-1:0]       rr_ptr_q, ptr_nxt, win_idx;
    logic [NUM_CPUS-1:0] gnt_q, arb_gnt;
    logic                arb_valid;
    logic                we_q, sel_we;
    logic [31:0]         addr_q, wdata_q, sel_addr, sel_wdata;
    logic [NUM_CPUS-1:0] ack_q, err_q, halt_q, halt_nxt, cand;
    logic [31:0]         rdata_q, rd_val;
    logic                wr_ok, rd_err, exec_err;
    halt_dec_t           dec;

    rr_arbiter #(.N(NUM_CPUS), .PW(PW)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (arb_gnt),
        .valid (arb_valid)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture mux for the winning requester
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CPUS; i++) begin
            if (arb_gnt[i]) begin
                sel_we    = bus.req_we[i];
                sel_addr  = bus.req_addr[i];
                sel_wdata = bus.req_wdata[i];
            end
        end
    end

    // Winner index and the next round-robin pointer
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_CPUS; i++) begin
            if (gnt_q[i]) win_idx = PW'(i);
        end
        ptr_nxt = (win_idx == PW'(NUM_CPUS - 1)) ? '0 : win_idx + 1'b1;
    end

    // Command evaluation for the latched access
    always_comb begin
        dec  = decode_halt(halt_t'(wdata_q[2:0]));
        cand = halt_q;
        for (int i = 0; i < NUM_CPUS; i++) begin
            if (i == int'(dec.core)) cand[i] = dec.halt;
        end
        // A halt that already applies leaves cand == halt_q, which can never be
        // all ones, so only a genuinely new last-core halt trips the &cand guard.
        wr_ok = (addr_q == CTRL_ADDR) && (wdata_q[31:3] == '0) &&
                (int'(dec.core) < NUM_CPUS) && !(&cand);
        halt_nxt = wr_ok ? cand : halt_q;
`ifdef CORE_MGR_READBACK_EN
        rd_err = (addr_q != CTRL_ADDR);
        rd_val = '0;
        if (!rd_err) rd_val[NUM_CPUS-1:0] = halt_q;
`else
        rd_err = 1'b1;
        rd_val = '0;
`endif
        exec_err = we_q ? !wr_ok : rd_err;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack_q    <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            halt_q   <= HALT_RST;
        end else begin
            ack_q <= '0;
            err_q <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        gnt_q   <= arb_gnt;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                    end
                end
                EXEC: begin
                    ack_q  <= gnt_q;
                    err_q  <= exec_err ? gnt_q : '0;
                    halt_q <= halt_nxt;
                    if (!we_q) rdata_q <= rd_val;
                end
                RESP: begin
                    rr_ptr_q <= ptr_nxt;
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ack = ack_q;
    assign bus.req_err = err_q;
    assign bus.rdata   = rdata_q;
    assign bus.halt_o  = halt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_core_halt_mgr.sv
module tb_core_halt_mgr;
    import core_halt_mgr_pkg::*;

    localparam logic [31:0] CA = 32'h8000_0000;
`ifdef CORE_MGR_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    core_halt_mgr_if #(.NUM_CPUS(2)) bus ();
    core_mgr_state_t dbg_state;

    core_halt_mgr #(.NUM_CPUS(2), .CTRL_ADDR(CA)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] oh(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // driver tasks
    task automatic drive(input logic idx, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.req_we[idx]    = we;
        bus.req_addr[idx]  = addr;
        bus.req_wdata[idx] = wdata;
        bus.req_valid[idx] = 1'b1;
    endtask

    // Waits (bounded) for an ack, checks it belongs to idx alone, then drops valid.
    task automatic wait_ack(input logic idx, input string tag, output logic e,
                            output logic [31:0] rd, output int cyc);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (bus.req_ack != 2'b00) break;
            if (cyc >= 20) break;
        end
        check({tag, "_ack"}, 32'(bus.req_ack), 32'(oh(idx)));
        e  = bus.req_err[idx];
        rd = bus.rdata;
        bus.req_valid[idx] = 1'b0;
    endtask

    task automatic access(input logic idx, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_err,
                          input logic [1:0] exp_halt, input logic [31:0] exp_rd,
                          input string tag);
        logic e;
        logic [31:0] rd;
        int cyc;
        drive(idx, we, addr, wdata);
        wait_ack(idx, tag, e, rd, cyc);
        check({tag, "_lat"}, 32'(cyc), 32'd2);
        check({tag, "_err"}, 32'(e), 32'(exp_err));
        check({tag, "_halt"}, 32'(bus.halt_o), 32'(exp_halt));
        check({tag, "_rdata"}, rd, exp_rd);
        @(negedge clk);
        check({tag, "_ackclr"}, 32'(bus.req_ack), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin : stim
        logic e0, e1;
        logic [31:0] r0, r1;
        int c0, c1;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_halt", 32'(bus.halt_o), 32'h2);
        check("rst_ack", 32'(bus.req_ack), 32'h0);
        check("rst_err", 32'(bus.req_err), 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_ptr", 32'(dut.rr_ptr_q), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // release core 1 from requester 0; pointer moves to 1
        access(1'b0, 1'b1, CA, 32'h1, 1'b0, 2'b00, 32'h0, "nhalt1");
        check("ptr_after_r0", 32'(dut.rr_ptr_q), 32'h1);

        // pointer at 1: requester 1 wins, requester 0 waits three cycles
        drive(1'b0, 1'b1, CA, 32'h7);
        drive(1'b1, 1'b1, CA, 32'h1);
        wait_ack(1'b1, "rr1_first", e1, r1, c1);
        check("rr1_first_lat", 32'(c1), 32'd2);
        check("rr1_first_err", 32'(e1), 32'd0);
        wait_ack(1'b0, "rr1_second", e0, r0, c0);
        check("rr1_second_lat", 32'(c0), 32'd3);
        check("rr1_second_err", 32'(e0), 32'd0);
        check("rr1_halt", 32'(bus.halt_o), 32'h0);
        @(negedge clk);
        check("rr1_ackclr", 32'(bus.req_ack), 32'd0);

        // bring pointer back to 0
        access(1'b1, 1'b1, CA, 32'h1, 1'b0, 2'b00, 32'h0, "nop_r1");
        check("ptr_zero", 32'(dut.rr_ptr_q), 32'h0);

        // pointer at 0: requester 0 first; requester 1 halts itself
        drive(1'b0, 1'b1, CA, 32'h1);
        drive(1'b1, 1'b1, CA, 32'h0);
        wait_ack(1'b0, "rr0_first", e0, r0, c0);
        check("rr0_first_lat", 32'(c0), 32'd2);
        check("rr0_first_err", 32'(e0), 32'd0);
        wait_ack(1'b1, "rr0_second", e1, r1, c1);
        check("rr0_second_lat", 32'(c1), 32'd3);
        check("rr0_second_err", 32'(e1), 32'd0);
        check("self_halt", 32'(bus.halt_o), 32'h2);
        @(negedge clk);
        check("rr0_ackclr", 32'(bus.req_ack), 32'd0);
        check("rr0_ptr_end", 32'(dut.rr_ptr_q), 32'h0);

        // rejects and no-change accepts with halt_o = 2'b10
        access(1'b0, 1'b1, CA, 32'h6, 1'b1, 2'b10, 32'h0, "last_core");
        access(1'b1, 1'b1, CA, 32'h0, 1'b0, 2'b10, 32'h0, "rehalt");
        access(1'b0, 1'b1, CA, 32'h2, 1'b1, 2'b10, 32'h0, "core_oob");
        access(1'b1, 1'b1, CA + 32'h4, 32'h1, 1'b1, 2'b10, 32'h0, "bad_addr");
        access(1'b0, 1'b1, CA, 32'h8, 1'b1, 2'b10, 32'h0, "bad_code");

        // swap the running core, then readback and rdata hold
        access(1'b0, 1'b1, CA, 32'h1, 1'b0, 2'b00, 32'h0, "rel1");
        access(1'b0, 1'b1, CA, 32'h6, 1'b0, 2'b01, 32'h0, "halt0");
        access(1'b1, 1'b0, CA, 32'h0, !RB, 2'b01, RB ? 32'h1 : 32'h0, "read01");
        access(1'b1, 1'b1, CA, 32'h0, 1'b1, 2'b01, RB ? 32'h1 : 32'h0, "last_core1");
        access(1'b1, 1'b1, CA, 32'h7, 1'b0, 2'b00, RB ? 32'h1 : 32'h0, "rel0");
        access(1'b0, 1'b0, CA + 32'h4, 32'h0, 1'b1, 2'b00, 32'h0, "read_bad");

        // read after reset from requester 1
        do_reset();
        access(1'b1, 1'b0, CA, 32'h0, !RB, 2'b10, RB ? 32'h2 : 32'h0, "read_rst");

        // reset while in EXEC aborts the access
        drive(1'b0, 1'b1, CA, 32'h1);
        @(negedge clk);
        check("abort_in_exec", 32'(dbg_state), 32'(EXEC));
        rst_n = 1'b0;
        #1;
        check("abort_ack", 32'(bus.req_ack), 32'h0);
        check("abort_halt", 32'(bus.halt_o), 32'h2);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_noack", 32'(bus.req_ack), 32'h0);
        access(1'b0, 1'b1, CA, 32'h1, 1'b0, 2'b00, 32'h0, "rereq");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
